// File: rtl/alu_req_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_pkg;

   localparam int unsigned DW_DEF  = 8;
   localparam int unsigned OPW_DEF = 7;

   localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
   localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
   localparam logic [2:0] IN_SEL_RESET   = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_WAIT = 2'b10,
      S_RESP = 2'b11
   } state_t;

endpackage

// File: rtl/alu_req_sched_if.sv
// Client, response and ALU-side signals of the scheduler, bundled with modports.
interface alu_req_sched_if #(
   parameter int unsigned DW  = 8,
   parameter int unsigned OPW = 7
);
   logic           on;
   logic           req0_valid, req0_ready;
   logic [DW-1:0]  req0_a, req0_b;
   logic [OPW-1:0] req0_op;
   logic           req1_valid, req1_ready;
   logic [DW-1:0]  req1_a, req1_b;
   logic [OPW-1:0] req1_op;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [DW-1:0]  rsp_data;
   logic [2:0]     alu_in_sel;
   logic [DW-1:0]  alu_num1, alu_num2, alu_out;
   logic [OPW-1:0] alu_out_sel;
   logic [1:0]     curr_state;

   modport slave (
      input  on, req0_valid, req0_a, req0_b, req0_op,
             req1_valid, req1_a, req1_b, req1_op, rsp_ready, alu_out,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             alu_in_sel, alu_num1, alu_num2, alu_out_sel, curr_state
   );

   modport master (
      output on, req0_valid, req0_a, req0_b, req0_op,
             req1_valid, req1_a, req1_b, req1_op, rsp_ready, alu_out,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             alu_in_sel, alu_num1, alu_num2, alu_out_sel, curr_state
   );

endinterface

// File: rtl/alu_req_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer favours requester 0 after reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_ptr;

   always_comb begin
      o_grant = '0;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
         default: o_grant = '0;
      endcase
   end

   // Pointer moves to whichever requester was not just served.
   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= 1'b0;
      else if (i_advance)
         r_ptr <= o_grant[0];
   end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one ALU between two requesters: grants round-robin, sequences
// load/persist, and returns the result tagged with the requester id.
module alu_req_sched
   import alu_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned OPW     = OPW_DEF,
   parameter int unsigned ALU_LAT = 2
) (
   input logic            clk,
   input logic            rst,
   alu_req_sched_if.slave bus
);

   localparam int unsigned CW = $clog2(ALU_LAT + 1);

   state_t         r_state, w_state_nxt;
   logic [DW-1:0]  r_a, r_b, r_rsp_data;
   logic [OPW-1:0] r_op;
   logic           r_id, r_rsp_err;
   logic [CW-1:0]  r_cnt;

   logic [1:0]     w_grant;
   logic           w_idle_on, w_xfer, w_sel_id, w_op_ok;
   logic [OPW-1:0] w_op;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     ({bus.req1_valid, bus.req0_valid}),
      .i_advance (w_xfer),
      .o_grant   (w_grant)
   );

   assign w_idle_on      = (r_state == S_IDLE) && bus.on;
   assign bus.req0_ready = w_idle_on && w_grant[0];
   assign bus.req1_ready = w_idle_on && w_grant[1];
   assign w_xfer         = bus.req0_ready || bus.req1_ready;
   assign w_sel_id       = w_grant[1];
   assign w_op           = w_sel_id ? bus.req1_op : bus.req0_op;
   assign w_op_ok        = (w_op != '0) && ((w_op & (w_op - OPW'(1))) == '0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_xfer) w_state_nxt = w_op_ok ? S_LOAD : S_RESP;
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: if (r_cnt == '0) w_state_nxt = S_RESP;
         S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_id       <= 1'b0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_xfer) begin
            r_a  <= w_sel_id ? bus.req1_a : bus.req0_a;
            r_b  <= w_sel_id ? bus.req1_b : bus.req0_b;
            r_op <= w_op;
            r_id <= w_sel_id;
            // Illegal ops skip the ALU and answer immediately with an error.
            if (!w_op_ok) begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end
         end
         if (r_state == S_LOAD)
            r_cnt <= CW'(ALU_LAT - 1);
         if (r_state == S_WAIT) begin
            if (r_cnt == '0) begin
               r_rsp_data <= bus.alu_out;
               r_rsp_err  <= 1'b0;
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   always_comb begin
      bus.alu_in_sel  = '0;
      bus.alu_num1    = '0;
      bus.alu_num2    = '0;
      bus.alu_out_sel = '0;
      case (r_state)
         S_LOAD: begin
            bus.alu_in_sel  = IN_SEL_LOAD;
            bus.alu_num1    = r_a;
            bus.alu_num2    = r_b;
            bus.alu_out_sel = r_op;
         end
         S_WAIT: begin
            bus.alu_in_sel  = IN_SEL_PERSIST;
            bus.alu_num1    = r_a;
            bus.alu_num2    = r_b;
            bus.alu_out_sel = r_op;
         end
         default: ;
      endcase
   end

   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.rsp_id     = r_id;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.curr_state = r_state;

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Two-requester scheduler that shares the single 8-bit ALU datapath (main) between two clients.
- Arbitrates round-robin and sequences the ALU's load and persist controls, then returns the result with the requester id.
- Sits between client logic and the ALU.
- Exposes its 2-bit current state for debug, in the same style as the ALU's currState.

Parameters:
- DW, 8, operand/result width.
- OPW, 7, one-hot operation-select width (ALU out_sel).
- ALU_LAT, 2, cycles from ALU load until alu_out is valid; must be >= 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- on  in  1  enable; when low, no new grants are issued.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a, req0_b  in  DW  requester 0 operands.
- req0_op  in  OPW  requester 0 one-hot operation.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the command.
- rsp_data  out  DW  ALU result.
- rsp_err  out  1  op was not one-hot.
- alu_in_sel  out  3  ALU input control {persist, load, reset}.
- alu_num1, alu_num2  out  DW  ALU operands.
- alu_out_sel  out  OPW  ALU operation select.
- alu_out  in  DW  ALU result.
- curr_state  out  2  FSM state.

Behaviour:
- States:
  - IDLE = 00: alu_in_sel = 000, alu_out_sel = 0.
  - LOAD = 01: alu_in_sel = 010; alu_num1, alu_num2 and alu_out_sel driven from captured command.
  - WAIT = 10: alu_in_sel = 100; operands and op held.
  - RESP = 11: alu_in_sel = 000; rsp_valid = 1.
- Reset:
  - State IDLE, round-robin pointer = 0 (requester 0 favoured).
  - All outputs 0: curr_state 00, alu_in_sel 000, rsp_*, ready signals.
  - Any in-flight command or pending response is dropped.
- Grant:
  - reqN_ready = (state == IDLE) & on & grant == N, combinational.
  - Grant goes to the only valid requester; if both are valid, to the pointer.
  - Transfer occurs on valid & ready. On transfer: capture a, b, op, id; move the pointer to the other requester.
- Next state after transfer:
  - op one-hot -> LOAD.
  - op zero or multi-hot -> RESP with rsp_err = 1, rsp_data = 0; the ALU is never driven.
- LOAD: one cycle, then WAIT with counter = ALU_LAT - 1.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle it reads 0, alu_out is registered into rsp_data with rsp_err = 0; next state RESP.
- Latency: transfer at cycle T gives LOAD at T+1, WAIT T+2..T+1+ALU_LAT, rsp_valid from T+2+ALU_LAT.
- RESP:
  - Holds rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_ready.
  - rsp_valid & rsp_ready -> IDLE. A new grant is possible in the following cycle, never in the same cycle.
- on deasserted mid-operation: the operation completes normally; only new grants are suppressed.
- Single outstanding command; no queuing. The requester not granted keeps valid high and waits.
- Counter width: $clog2(ALU_LAT+1).

Decomposition:
- Package alu_pkg:
  - State encodings (S_IDLE, S_LOAD, S_WAIT, S_RESP).
  - IN_SEL_PERSIST = 3'b100, IN_SEL_LOAD = 3'b010, IN_SEL_RESET = 3'b001.
  - Default DW / OPW.
- One sub-module, rr_arb2: 2-way round-robin arbiter with req[1:0], advance and grant outputs.

Test Plan (ALU_LAT = 2; bench ALU model: op[0] add, op[1] sub, op[3] AND, registered result):
- Basic AND: rst, then req0 a = 0x57, b = 0x1A, op = 0001000 accepted at T -> alu_in_sel 010 at T+1, 100 at T+2..T+3; rsp_valid at T+4 with id 0, data 0x12, err 0.
- Both valid after reset: req0 add 0x57 + 0x1A and req1 sub 0x00 - 0x01 -> req0 granted first, rsp 0x71 id 0; then req1 granted, rsp 0xFF id 1. Repeat with both valid -> req0 granted again.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp outputs stable, no ready asserted, curr_state stays 11; one cycle after the rsp_ready handshake, req ready asserts.
- Illegal op 0000011 -> LOAD skipped, alu_in_sel stays 000; rsp_valid at T+1 with err 1, data 0.
- on = 0 with req1_valid high -> req1_ready stays 0. on dropped during WAIT -> in-flight response still delivered.
- rst asserted in WAIT -> next cycle curr_state 00, rsp_valid 0, alu_in_sel 000, pointer 0; no response is emitted for the aborted command.
